// File: rtl/ddr_axi_rw_scheduler_if.sv
// Bundle between the scheduler, its two burst requesters and the
// shared AXI4 port 0 of the DDR controller.
interface ddr_axi_rw_scheduler_if;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [7:0]   wr_len;
    logic         wr_gnt;
    logic [255:0] wr_wdata;
    logic         wr_wvalid;
    logic         wr_wready;
    logic         wr_done;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic [7:0]   rd_len;
    logic         rd_gnt;
    logic [255:0] rd_rdata;
    logic         rd_rvalid;
    logic         rd_done;
    logic         rd_err;
    logic         busy;
    logic [7:0]   ddr_aid;
    logic [31:0]  ddr_aaddr;
    logic [7:0]   ddr_alen;
    logic [2:0]   ddr_asize;
    logic [1:0]   ddr_aburst;
    logic [1:0]   ddr_alock;
    logic         ddr_avalid;
    logic         ddr_aready;
    logic         ddr_atype;
    logic [7:0]   ddr_wid;
    logic [255:0] ddr_wdata;
    logic [31:0]  ddr_wstrb;
    logic         ddr_wlast;
    logic         ddr_wvalid;
    logic         ddr_wready;
    logic [255:0] ddr_rdata;
    logic         ddr_rlast;
    logic         ddr_rvalid;
    logic [1:0]   ddr_rresp;
    logic         ddr_rready;
    logic         ddr_bvalid;
    logic         ddr_bready;

    modport master (
        input  wr_req, wr_addr, wr_len, wr_wdata, wr_wvalid,
        input  rd_req, rd_addr, rd_len,
        input  ddr_aready, ddr_wready, ddr_rdata, ddr_rlast,
        input  ddr_rvalid, ddr_rresp, ddr_bvalid,
        output wr_gnt, wr_wready, wr_done,
        output rd_gnt, rd_rdata, rd_rvalid, rd_done, rd_err, busy,
        output ddr_aid, ddr_aaddr, ddr_alen, ddr_asize, ddr_aburst,
        output ddr_alock, ddr_avalid, ddr_atype,
        output ddr_wid, ddr_wdata, ddr_wstrb, ddr_wlast, ddr_wvalid,
        output ddr_rready, ddr_bready
    );

    modport slave (
        output wr_req, wr_addr, wr_len, wr_wdata, wr_wvalid,
        output rd_req, rd_addr, rd_len,
        output ddr_aready, ddr_wready, ddr_rdata, ddr_rlast,
        output ddr_rvalid, ddr_rresp, ddr_bvalid,
        input  wr_gnt, wr_wready, wr_done,
        input  rd_gnt, rd_rdata, rd_rvalid, rd_done, rd_err, busy,
        input  ddr_aid, ddr_aaddr, ddr_alen, ddr_asize, ddr_aburst,
        input  ddr_alock, ddr_avalid, ddr_atype,
        input  ddr_wid, ddr_wdata, ddr_wstrb, ddr_wlast, ddr_wvalid,
        input  ddr_rready, ddr_bready
    );
endinterface

// File: rtl/ddr_axi_rw_scheduler.sv
// Round-robin burst scheduler sharing DDR AXI4 port 0 between the
// UART write path and the readback path, one whole burst at a time.
module ddr_axi_rw_scheduler #(
    parameter logic [7:0] AXI_ID   = 8'h00,
    parameter logic [2:0] AXI_SIZE = 3'b101
) (
    input  logic axi_clk,
    input  logic rst,
    ddr_axi_rw_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WRESP, RDATA
    } state_t;

    state_t      r_state;
    logic        r_ptr_wr;
    logic        r_type;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_wr_done;
    logic        r_rd_err;

    logic w_idle;
    logic w_gnt_wr;
    logic w_gnt_rd;
    logic w_whs;
    logic w_rbeat;
    logic w_last;
    logic w_bhs;

    // The wr_done cycle is held off so a request arriving with it waits one cycle
    assign w_idle   = (r_state == IDLE) && !r_wr_done && !rst;
    assign w_gnt_wr = w_idle && bus.wr_req && (!bus.rd_req || r_ptr_wr);
    assign w_gnt_rd = w_idle && bus.rd_req && (!bus.wr_req || !r_ptr_wr);
    assign w_last   = (r_cnt == r_len);
    assign w_whs    = (r_state == WDATA) && bus.wr_wvalid && bus.ddr_wready;
    assign w_rbeat  = (r_state == RDATA) && bus.ddr_rvalid;
    assign w_bhs    = (r_state == WRESP) && bus.ddr_bvalid;

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr_wr  <= 1'b1;
            r_type    <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wr_done <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_wr_done <= w_bhs;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_wr || w_gnt_rd) begin
                        r_addr   <= w_gnt_wr ? bus.wr_addr : bus.rd_addr;
                        r_len    <= w_gnt_wr ? bus.wr_len : bus.rd_len;
                        r_type   <= w_gnt_wr;
                        r_ptr_wr <= !w_gnt_wr;
                        r_cnt    <= '0;
                        r_state  <= ADDR;
                        if (w_gnt_rd)
                            r_rd_err <= 1'b0;
                    end
                end
                ADDR: begin
                    if (bus.ddr_aready)
                        r_state <= r_type ? WDATA : RDATA;
                end
                WDATA: begin
                    if (w_whs) begin
                        if (w_last)
                            r_state <= WRESP;
                        else
                            r_cnt <= r_cnt + 8'd1;
                    end
                end
                WRESP: begin
                    if (bus.ddr_bvalid)
                        r_state <= IDLE;
                end
                RDATA: begin
                    if (w_rbeat) begin
                        // Any bad response or rlast/count disagreement marks the burst
                        if ((bus.ddr_rresp != 2'b00) || (bus.ddr_rlast != w_last))
                            r_rd_err <= 1'b1;
                        if (r_cnt != 8'hff)
                            r_cnt <= r_cnt + 8'd1;
                        if (bus.ddr_rlast)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wr_gnt     = w_gnt_wr;
    assign bus.rd_gnt     = w_gnt_rd;
    assign bus.busy       = (r_state != IDLE);
    assign bus.ddr_aid    = AXI_ID;
    assign bus.ddr_aaddr  = r_addr;
    assign bus.ddr_alen   = r_len;
    assign bus.ddr_asize  = AXI_SIZE;
    assign bus.ddr_aburst = 2'b01;
    assign bus.ddr_alock  = 2'b00;
    assign bus.ddr_avalid = (r_state == ADDR);
    assign bus.ddr_atype  = r_type;
    assign bus.ddr_wid    = AXI_ID;
    assign bus.ddr_wdata  = bus.wr_wdata;
    assign bus.ddr_wstrb  = '1;
    assign bus.ddr_wvalid = (r_state == WDATA) && bus.wr_wvalid;
    assign bus.ddr_wlast  = (r_state == WDATA) && w_last;
    assign bus.wr_wready  = (r_state == WDATA) && bus.ddr_wready;
    assign bus.ddr_bready = (r_state == WRESP);
    assign bus.wr_done    = r_wr_done;
    assign bus.ddr_rready = (r_state == RDATA);
    assign bus.rd_rvalid  = w_rbeat;
    assign bus.rd_rdata   = bus.ddr_rdata;
    assign bus.rd_done    = w_rbeat && bus.ddr_rlast;
    assign bus.rd_err     = r_rd_err;

endmodule

// File: tb/tb_ddr_axi_rw_scheduler.sv
// Randomized bench for ddr_axi_rw_scheduler: requester and DDR models
// plus a round-robin arbitration model and burst scoreboards.
module tb_ddr_axi_rw_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr_axi_rw_scheduler_if bus();

    ddr_axi_rw_scheduler dut (
        .axi_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    bit m_ptr_wr;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic idle_inputs();
        bus.wr_req = 0; bus.wr_addr = 0; bus.wr_len = 0;
        bus.wr_wdata = 0; bus.wr_wvalid = 0;
        bus.rd_req = 0; bus.rd_addr = 0; bus.rd_len = 0;
        bus.ddr_aready = 0; bus.ddr_wready = 0;
        bus.ddr_rdata = 0; bus.ddr_rlast = 0; bus.ddr_rvalid = 0;
        bus.ddr_rresp = 0; bus.ddr_bvalid = 0;
    endtask

    // Raise requests (w/r) or, with neither, wait on ones already pending
    task automatic request(input bit w, input bit r,
                           input logic [31:0] wa, input logic [7:0] wl,
                           input logic [31:0] ra, input logic [7:0] rl,
                           output bit got_w, output logic [31:0] a,
                           output logic [7:0] l, output bit ok);
        bit exp_w;
        ok = 0; got_w = 0; a = 0; l = 0;
        if (w || r) begin
            @(negedge clk);
            if (w) begin
                bus.wr_req = 1; bus.wr_addr = wa; bus.wr_len = wl;
            end
            if (r) begin
                bus.rd_req = 1; bus.rd_addr = ra; bus.rd_len = rl;
            end
        end
        for (int c = 0; c < 20 && !ok; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.wr_gnt || bus.rd_gnt) begin
                ok = 1;
                exp_w = bus.wr_req && (!bus.rd_req || m_ptr_wr);
                chk("gnt_wr", bus.wr_gnt, exp_w);
                chk("gnt_rd", bus.rd_gnt, !exp_w);
                got_w = exp_w;
                a = exp_w ? bus.wr_addr : bus.rd_addr;
                l = exp_w ? bus.wr_len : bus.rd_len;
                m_ptr_wr = !exp_w;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic addr_phase(input bit is_w, input logic [31:0] a,
                              input logic [7:0] l, input int dly);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (is_w) bus.wr_req = 0;
                else bus.rd_req = 0;
            end
            bus.ddr_aready = (c == dly);
            #1;
            chk("avalid", bus.ddr_avalid, 1);
            chk("aaddr", bus.ddr_aaddr, a);
            chk("alen", bus.ddr_alen, l);
            chk("atype", bus.ddr_atype, is_w);
            chk("gnt_busy", bus.wr_gnt | bus.rd_gnt, 0);
            if (c == 0 && !is_w) chk("rd_err_clr", bus.rd_err, 0);
        end
    endtask

    task automatic w_phase(input logic [7:0] l, input bit rnd,
                           input logic [255:0] base);
        logic [255:0] d[$];
        int beat = 0;
        int budget = 0;
        int bd;
        for (int i = 0; i <= int'(l); i++)
            d.push_back(base != 0 ? base + 256'(i) : rnd256());
        while (beat <= int'(l) && budget < 300) begin
            @(negedge clk);
            budget++;
            bus.ddr_aready = 0;
            bus.wr_wdata = d[beat];
            bus.wr_wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ddr_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("wr_wready", bus.wr_wready, bus.ddr_wready);
            chk("ddr_wvalid", bus.ddr_wvalid, bus.wr_wvalid);
            if (bus.wr_wvalid && bus.ddr_wready) begin
                chk("wdata", bus.ddr_wdata, d[beat]);
                chk("wlast", bus.ddr_wlast, beat == int'(l));
                beat++;
            end
        end
        if (beat <= int'(l)) chk("w_timeout", 0, 1);
        bd = $urandom_range(0, 2);
        for (int c = 0; c <= bd; c++) begin
            @(negedge clk);
            bus.wr_wvalid = 0;
            bus.ddr_wready = 0;
            bus.ddr_bvalid = (c == bd);
            #1;
            chk("bready", bus.ddr_bready, 1);
            chk("wr_done_early", bus.wr_done, 0);
        end
        @(negedge clk);
        bus.ddr_bvalid = 0;
        #1;
        chk("wr_done", bus.wr_done, 1);
        chk("busy_after_w", bus.busy, 0);
    endtask

    task automatic r_phase(input logic [7:0] l, input int last_at,
                           input int err_beat);
        bit exp_err;
        int beat = 0;
        int budget = 0;
        exp_err = (last_at != int'(l)) ||
                  (err_beat >= 0 && err_beat <= last_at);
        while (beat <= last_at && budget < 300) begin
            @(negedge clk);
            budget++;
            bus.ddr_aready = 0;
            bus.ddr_rvalid = ($urandom_range(0, 3) != 0);
            bus.ddr_rdata = rnd256();
            bus.ddr_rlast = (beat == last_at);
            bus.ddr_rresp = (beat == err_beat) ? 2'b10 : 2'b00;
            #1;
            chk("rready", bus.ddr_rready, 1);
            chk("rd_rvalid", bus.rd_rvalid, bus.ddr_rvalid);
            if (bus.ddr_rvalid) begin
                chk("rd_rdata", bus.rd_rdata, bus.ddr_rdata);
                chk("rd_done", bus.rd_done, beat == last_at);
                beat++;
            end else begin
                chk("rd_done_idle", bus.rd_done, 0);
            end
        end
        if (beat <= last_at) chk("r_timeout", 0, 1);
        @(negedge clk);
        bus.ddr_rvalid = 0; bus.ddr_rlast = 0; bus.ddr_rresp = 0;
        #1;
        chk("busy_after_r", bus.busy, 0);
        chk("rd_err", bus.rd_err, exp_err);
    endtask

    task automatic run(input bit w, input bit r, input int dly,
                       input bit rnd);
        bit got_w, ok;
        logic [31:0] a;
        logic [7:0] l;
        int mode, last_at, err_beat;
        request(w, r, $urandom(), 8'($urandom_range(0, 7)),
                $urandom(), 8'($urandom_range(0, 7)), got_w, a, l, ok);
        if (!ok) return;
        addr_phase(got_w, a, l, dly);
        if (got_w) begin
            w_phase(l, rnd, 0);
        end else begin
            mode = $urandom_range(0, 4);
            last_at = int'(l);
            err_beat = -1;
            if (mode == 0 && l > 0) last_at = $urandom_range(0, int'(l) - 1);
            if (mode == 1) err_beat = $urandom_range(0, int'(l));
            if (mode == 2) last_at = int'(l) + $urandom_range(1, 2);
            r_phase(l, last_at, err_beat);
        end
    endtask

    initial begin
        bit got_w, ok;
        logic [31:0] a;
        logic [7:0] l;
        bit w, r;
        rst = 1;
        idle_inputs();
        m_ptr_wr = 1;
        repeat (2) @(negedge clk);
        bus.wr_req = 1; bus.rd_req = 1;
        #1;
        chk("rst_gnt", {bus.wr_gnt, bus.rd_gnt}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_avalid", bus.ddr_avalid, 0);
        chk("rst_aaddr", bus.ddr_aaddr, 0);
        chk("rst_alen", bus.ddr_alen, 0);
        chk("rst_atype", bus.ddr_atype, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("rst_dones", {bus.wr_done, bus.rd_done}, 0);
        chk("rst_readies", {bus.wr_wready, bus.ddr_bready, bus.ddr_rready}, 0);
        chk("const_ids", {bus.ddr_aid, bus.ddr_wid}, 16'h0000);
        chk("const_asize", bus.ddr_asize, 3'b101);
        chk("const_burst", {bus.ddr_aburst, bus.ddr_alock}, 4'b0100);
        chk("const_wstrb", bus.ddr_wstrb, 32'hffff_ffff);
        @(negedge clk);
        bus.wr_req = 0; bus.rd_req = 0;
        rst = 0;

        // single write of A0..A3, then single-beat read
        request(1, 0, 32'h1000, 8'd3, 0, 0, got_w, a, l, ok);
        if (ok) begin
            addr_phase(got_w, a, l, 0);
            w_phase(l, 0, 256'hA0);
        end
        request(0, 1, 0, 0, 32'h2000, 8'd0, got_w, a, l, ok);
        if (ok) begin
            addr_phase(got_w, a, l, 0);
            r_phase(l, 0, -1);
        end

        // simultaneous requests alternate; aready stalled for 5 cycles
        run(1, 1, 5, 0);
        run(0, 0, 0, 0);
        run(1, 1, 0, 0);
        run(0, 0, 2, 0);

        // early rlast sets rd_err, next clean read clears it at grant
        request(0, 1, 0, 0, 32'h3000, 8'd3, got_w, a, l, ok);
        if (ok) begin
            addr_phase(got_w, a, l, 0);
            r_phase(l, 1, -1);
        end
        request(0, 1, 0, 0, 32'h3100, 8'd2, got_w, a, l, ok);
        if (ok) begin
            addr_phase(got_w, a, l, 1);
            r_phase(l, 2, -1);
        end

        // len=7 write with random flow control on both sides
        request(1, 0, 32'h4000, 8'd7, 0, 0, got_w, a, l, ok);
        if (ok) begin
            addr_phase(got_w, a, l, 0);
            w_phase(l, 1, 0);
        end

        // reset during beat 2 of a 4-beat write
        request(1, 0, 32'h5000, 8'd3, 0, 0, got_w, a, l, ok);
        if (ok) begin
            addr_phase(got_w, a, l, 0);
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                bus.ddr_aready = 0;
                bus.wr_wvalid = 1; bus.ddr_wready = 1;
                bus.wr_wdata = rnd256();
                #1;
                chk("rst_pre_wlast", bus.ddr_wlast, 0);
            end
            @(negedge clk);
            bus.wr_wvalid = 1; bus.ddr_wready = 1;
            #1;
            chk("rst_pre_wvalid", bus.ddr_wvalid, 1);
            rst = 1;
            #1;
            chk("rst_wvalid", bus.ddr_wvalid, 0);
            chk("rst_wready", bus.wr_wready, 0);
            chk("rst_busy_mid", bus.busy, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                bus.wr_wvalid = 0; bus.ddr_wready = 0;
                #1;
                chk("rst_no_done", bus.wr_done, 0);
            end
            @(negedge clk);
            rst = 0;
            m_ptr_wr = 1;
            #1;
            chk("post_rst_done", bus.wr_done, 0);
        end
        run(1, 0, 1, 1);

        // random mix of requests, lengths, stalls and read errors
        for (int k = 0; k < 14; k++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r) w = 1;
            run(w, r, $urandom_range(0, 3), 1);
            if (w && r) run(0, 0, $urandom_range(0, 3), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
